// File: rtl/slave_split_port_pkg.sv
// split_pkg: shared types and constants for the slave-side split agent.
//   split_state_t  : agent FSM state encoding
//   SPLIT_ASSERT   : level driven on the split line while a split is pending
//   SPLIT_RELEASE  : level driven for the one-cycle completion edge
//   SID_NONE       : "no slave holds a split" id, shared with bus_controller
package split_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HOLD     = 3'd1,
    RELEASE  = 3'd2,
    WAIT_ACK = 3'd3,
    RESUME   = 3'd4
  } split_state_t;

  localparam logic SPLIT_ASSERT  = 1'b1;
  localparam logic SPLIT_RELEASE = 1'b0;

  localparam int unsigned SID_W = 4;
  localparam logic [SID_W-1:0] SID_NONE = '1;

endpackage

// File: rtl/split_sat_counter.sv
// split_sat_counter: saturating up-counter, never wraps.
// Ports:
//   clk     : clock
//   rst     : synchronous active-high reset (count -> 0)
//   clr     : synchronous clear, has priority over en
//   en      : count up by one while below MAX
//   cnt     : current count
//   at_max  : count equals MAX
module split_sat_counter #(
  parameter int unsigned MAX = 4,
  parameter int unsigned W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         at_max
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign at_max = (cnt_q == W'(MAX));
  assign cnt    = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !at_max) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/slave_split_port.sv
// slave_split_port: slave-side agent on one slaves[i] split wire to bus_controller.
// Holds the line high while the core is busy (at least MIN_HOLD cycles), drives
// one low cycle to mark completion, then waits for the controller's one-cycle
// high acknowledge before pulsing resume to the core.
// Ports:
//   clk        : system clock, posedge
//   rst        : synchronous active-high reset
//   split_line : split wire (inout, pulled down externally)
//   split_req  : core asks for a split (sampled in IDLE only)
//   work_done  : core response ready (pulse or level, honoured in HOLD only)
//   resume     : one-cycle pulse, original master owns the bus again
//   split_busy : high in every state except IDLE
//   ack_err    : sticky acknowledge-timeout flag
// Build option: define SLAVE_SPLIT_ACK_TIMEOUT_EN to abort WAIT_ACK after
// ACK_TIMEOUT cycles with ack_err set; otherwise WAIT_ACK waits forever and
// ack_err is tied low.
//
// state    | meaning
// IDLE     | line released, waiting for split_req
// HOLD     | line driven high, waiting for min hold and work_done
// RELEASE  | line driven low for one cycle
// WAIT_ACK | line released, waiting for controller acknowledge
// RESUME   | one-cycle resume pulse to the core
module slave_split_port
  import split_pkg::*;
#(
  parameter int unsigned MIN_HOLD    = 4,
  parameter int unsigned ACK_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  inout  wire  split_line,
  input  logic split_req,
  input  logic work_done,
  output logic resume,
  output logic split_busy,
  output logic ack_err
);

  localparam int unsigned HOLD_W = $clog2(MIN_HOLD + 1);

  split_state_t state_q;
  logic         oe_q;
  logic         do_q;
  logic         resume_q;
  logic         busy_q;
  logic         done_lat_q;

  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_at_max;
  logic              hold_clr;
  logic              hold_en;
  logic              hold_met;

  assign split_line = oe_q ? do_q : 1'bz;
  assign resume     = resume_q;
  assign split_busy = busy_q;

  assign hold_clr = (state_q == IDLE) && split_req;
  assign hold_en  = (state_q == HOLD);

  // The counter holds the number of completed HOLD cycles, so the cycle being
  // evaluated is the (cnt+1)-th; the hold is met once that reaches MIN_HOLD.
  assign hold_met = hold_at_max || (hold_cnt == HOLD_W'(MIN_HOLD - 1));

  split_sat_counter #(
    .MAX (MIN_HOLD),
    .W   (HOLD_W)
  ) u_hold_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (hold_clr),
    .en     (hold_en),
    .cnt    (hold_cnt),
    .at_max (hold_at_max)
  );

`ifdef SLAVE_SPLIT_ACK_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(ACK_TIMEOUT + 1);

  logic [TO_W-1:0] to_cnt;
  logic            to_at_max;
  logic            to_met;
  logic            ack_err_q;

  // Same off-by-one as the hold count: abort at the end of the
  // ACK_TIMEOUT-th WAIT_ACK cycle.
  assign to_met  = to_at_max || (to_cnt == TO_W'(ACK_TIMEOUT - 1));
  assign ack_err = ack_err_q;

  split_sat_counter #(
    .MAX (ACK_TIMEOUT),
    .W   (TO_W)
  ) u_to_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_q == RELEASE),
    .en     (state_q == WAIT_ACK),
    .cnt    (to_cnt),
    .at_max (to_at_max)
  );
`else
  assign ack_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      oe_q       <= 1'b0;
      do_q       <= SPLIT_RELEASE;
      resume_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_lat_q <= 1'b0;
`ifdef SLAVE_SPLIT_ACK_TIMEOUT_EN
      ack_err_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          resume_q <= 1'b0;
          if (split_req) begin
            state_q    <= HOLD;
            oe_q       <= 1'b1;
            do_q       <= SPLIT_ASSERT;
            busy_q     <= 1'b1;
            done_lat_q <= 1'b0;
`ifdef SLAVE_SPLIT_ACK_TIMEOUT_EN
            ack_err_q  <= 1'b0;
`endif
          end
        end
        HOLD: begin
          if (work_done) begin
            done_lat_q <= 1'b1;
          end
          if (hold_met && (done_lat_q || work_done)) begin
            state_q <= RELEASE;
            do_q    <= SPLIT_RELEASE;
          end
        end
        RELEASE: begin
          state_q <= WAIT_ACK;
          oe_q    <= 1'b0;
        end
        WAIT_ACK: begin
          if (split_line == SPLIT_ASSERT) begin
            state_q  <= RESUME;
            resume_q <= 1'b1;
          end
`ifdef SLAVE_SPLIT_ACK_TIMEOUT_EN
          else if (to_met) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            ack_err_q <= 1'b1;
          end
`endif
        end
        RESUME: begin
          state_q  <= IDLE;
          resume_q <= 1'b0;
          busy_q   <= 1'b0;
        end
        default: begin
          state_q  <= IDLE;
          oe_q     <= 1'b0;
          resume_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slave_split_port.sv
module tb_slave_split_port;

  localparam int MIN_HOLD = 4;
`ifdef SLAVE_SPLIT_ACK_TIMEOUT_EN
  localparam int ACK_TIMEOUT = 16;
`else
  localparam int ACK_TIMEOUT = 1024;
`endif

  logic clk = 1'b0;
  logic rst;
  logic split_req;
  logic work_done;
  logic resume;
  logic split_busy;
  logic ack_err;
  logic ack_drv;
  wire  split_line;

  // Controller side: acknowledge is a driven high, otherwise the pull-down wins.
  assign split_line = ack_drv ? 1'b1 : 1'bz;
  pulldown (split_line);

  always #5 clk = ~clk;

  slave_split_port #(
    .MIN_HOLD    (MIN_HOLD),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .split_line (split_line),
    .split_req  (split_req),
    .work_done  (work_done),
    .resume     (resume),
    .split_busy (split_busy),
    .ack_err    (ack_err)
  );

  int errors = 0;
  int checks = 0;
  logic exp_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string where, input int c, input logic eb,
                            input logic er, input bit chk_line, input logic el);
    check($sformatf("%s busy c=%0d", where, c), split_busy, eb);
    check($sformatf("%s resume c=%0d", where, c), resume, er);
    check($sformatf("%s ack_err c=%0d", where, c), ack_err, exp_err);
    if (chk_line) check($sformatf("%s line c=%0d", where, c), split_line, el);
  endtask

  // Cycles with no split request; stray work_done must change nothing.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      split_req = 1'b0;
      work_done = 1'($urandom_range(0, 1));
      ack_drv   = 1'b0;
      @(negedge clk);
      check_outs("idle", i, 1'b0, 1'b0, 1'b1, 1'b0);
      @(posedge clk); #1;
    end
    work_done = 1'b0;
  endtask

  // One split transaction, expected timeline derived from the rules:
  //   cycle 0             : IDLE, request presented
  //   1 .. hold_len       : line high, hold_len = max(MIN_HOLD, j)
  //   hold_len+1          : line driven low
  //   hold_len+2 .. ack_c : released, acknowledge driven in cycle ack_c
  //   ack_c+1             : resume pulse
  // mode: 0 quiet, 1 random stray req/done, 2 split_req held high throughout.
  // rst_at >= 0 asserts reset in that cycle and ends the transaction after it.
  task automatic run_txn(input int j, input int a, input int mode, input int rst_at);
    int hold_len;
    int ack_c;
    int last;
    logic eb, er, el;
    bit chk_line;
    hold_len = (j > MIN_HOLD) ? j : MIN_HOLD;
    ack_c    = hold_len + 2 + a;
    last     = ack_c + 1;
    for (int c = 0; c <= last; c++) begin
      if (c == 0 || mode == 2) split_req = 1'b1;
      else if (mode == 1)      split_req = 1'($urandom_range(0, 1));
      else                     split_req = 1'b0;
      if (c >= 1 && c <= hold_len)
        work_done = (c == j) || (c > j && mode != 0 && $urandom_range(0, 1) == 1);
      else
        work_done = (mode != 0) && ($urandom_range(0, 3) == 0);
      ack_drv = (c == ack_c);
      rst     = (c == rst_at);
      @(negedge clk);
      chk_line = 1'b1;
      er = 1'b0;
      el = 1'b0;
      if (c == 0) begin
        eb = 1'b0;
      end else if (c <= hold_len) begin
        eb = 1'b1;
        el = 1'b1;
      end else if (c == last) begin
        eb = 1'b1;
        er = 1'b1;
      end else begin
        eb = 1'b1;
        chk_line = (c != ack_c);
      end
      check_outs("txn", c, eb, er, chk_line, el);
      if (c == 0) exp_err = 1'b0;
      @(posedge clk); #1;
      if (c == rst_at) begin
        rst       = 1'b0;
        split_req = 1'b0;
        work_done = 1'b0;
        ack_drv   = 1'b0;
        exp_err   = 1'b0;
        @(negedge clk);
        check_outs("after_rst", c + 1, 1'b0, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        return;
      end
    end
    split_req = 1'b0;
    work_done = 1'b0;
    ack_drv   = 1'b0;
  endtask

`ifdef SLAVE_SPLIT_ACK_TIMEOUT_EN
  // No acknowledge: after ACK_TIMEOUT released cycles the agent gives up.
  task automatic run_timeout();
    int last;
    logic eb, el;
    last = MIN_HOLD + 2 + ACK_TIMEOUT;
    for (int c = 0; c <= last; c++) begin
      split_req = (c == 0);
      work_done = (c == 1);
      ack_drv   = 1'b0;
      @(negedge clk);
      if (c == last) exp_err = 1'b1;
      eb = (c != 0) && (c != last);
      el = (c >= 1) && (c <= MIN_HOLD);
      check_outs("timeout", c, eb, 1'b0, 1'b1, el);
      if (c == 0) exp_err = 1'b0;
      @(posedge clk); #1;
    end
    split_req = 1'b0;
    work_done = 1'b0;
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    split_req = 1'b0;
    work_done = 1'b0;
    ack_drv   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_outs("reset", 0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_cycles(2);

    // done long after the request, acknowledge after two waiting cycles
    run_txn(10, 2, 0, -1);
    idle_cycles(1);
    // early done: hold still enforced, done latched
    run_txn(1, 0, 0, -1);
    idle_cycles(1);
    run_txn(MIN_HOLD, 0, 0, -1);
    // split_req held high: requests ignored while busy, one idle cycle between splits
    run_txn(3, 1, 2, -1);
    run_txn(5, 0, 2, -1);
    idle_cycles(2);
    // reset during HOLD, then during WAIT_ACK
    run_txn(6, 0, 0, 2);
    idle_cycles(1);
    run_txn(2, 3, 0, MIN_HOLD + 3);
    idle_cycles(1);
`ifdef SLAVE_SPLIT_ACK_TIMEOUT_EN
    run_timeout();
    idle_cycles(1);
    run_txn(2, 1, 0, -1);
    idle_cycles(1);
`endif

    for (int t = 0; t < 40; t++) begin
      int j, a, mode, r;
      j    = int'($urandom_range(1, 12));
      a    = int'($urandom_range(0, 5));
      mode = int'($urandom_range(0, 2));
      r    = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 20)) : -1;
      run_txn(j, a, mode, r);
      idle_cycles(int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
